// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage HI/LO multiply/divide unit:
// MIPS funct codes of the HI/LO group and the sequencer state encoding.
package ex_muldiv_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/ex_muldiv_unit_muldiv_datapath.sv
// Combinational iteration step (shift-add multiply / restoring divide) and the
// final two's-complement sign correction for the iterative HI/LO unit.
module muldiv_datapath
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   opb_i,
    input  logic              is_div_i,
    input  logic              neg_q_i,
    input  logic              neg_r_i,
    output logic [2*XLEN-1:0] acc_step_o,
    output logic [XLEN-1:0]   hi_fix_o,
    output logic [XLEN-1:0]   lo_fix_o
);

    logic              b_zero_s;
    logic [XLEN:0]     sum_s;
    logic [XLEN:0]     diff_s;
    logic [XLEN-1:0]   rem_s;
    logic              q_bit_s;
    logic [2*XLEN-1:0] prod_s;

    // One iteration: acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        b_zero_s = (opb_i == '0);
        sum_s    = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opb_i} : {(XLEN+1){1'b0}});
        // Shifted remainder is < 2*divisor, so a 33-bit difference gives an exact sign bit
        diff_s   = acc_i[2*XLEN-1:XLEN-1] - {1'b0, opb_i};
        q_bit_s  = b_zero_s || !diff_s[XLEN];
        rem_s    = q_bit_s ? diff_s[XLEN-1:0] : acc_i[2*XLEN-2:XLEN-1];
        if (is_div_i) begin
            acc_step_o = {rem_s, acc_i[XLEN-2:0], q_bit_s};
        end else begin
            acc_step_o = {sum_s, acc_i[XLEN-1:1]};
        end
    end

    // Sign correction; a zero divisor leaves all-ones quotient and dividend magnitude untouched
    always_comb begin
        prod_s = neg_q_i ? -acc_i : acc_i;
        if (is_div_i) begin
            lo_fix_o = (neg_q_i && !b_zero_s) ? -acc_i[XLEN-1:0] : acc_i[XLEN-1:0];
            hi_fix_o = (neg_r_i && !b_zero_s) ? -acc_i[2*XLEN-1:XLEN] : acc_i[2*XLEN-1:XLEN];
        end else begin
            lo_fix_o = prod_s[XLEN-1:0];
            hi_fix_o = prod_s[2*XLEN-1:XLEN];
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage MIPS HI/LO unit: decode, IDLE/RUN/FIX sequencer, stall generation
// and the architectural HI/LO registers around an iterative datapath.
module ex_muldiv_unit
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_rtype,
    input  logic [5:0]      ex_funct,
    input  logic [XLEN-1:0] ex_opA,
    input  logic [XLEN-1:0] ex_opB,
    input  logic            ex_flush,
    output logic            md_stall,
    output logic            md_busy,
    output logic [XLEN-1:0] md_result,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d, acc_step_s;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [XLEN-1:0]   hi_fix_s, lo_fix_s, mag_a_s, mag_b_s;
    logic              is_div_q, is_div_d, neg_q_q, neg_q_d, neg_r_q, neg_r_d;
    logic              start_s, mf_s, mt_s, sign_a_s, sign_b_s;

    // Instruction decode and operand magnitudes
    always_comb begin
        start_s  = ex_rtype && ((ex_funct == FUNCT_MULT) || (ex_funct == FUNCT_MULTU) ||
                                (ex_funct == FUNCT_DIV)  || (ex_funct == FUNCT_DIVU));
        mf_s     = ex_rtype && ((ex_funct == FUNCT_MFHI) || (ex_funct == FUNCT_MFLO));
        mt_s     = ex_rtype && ((ex_funct == FUNCT_MTHI) || (ex_funct == FUNCT_MTLO));
        // funct bit 0 clear selects the signed variants (MULT, DIV)
        sign_a_s = !ex_funct[0] && ex_opA[XLEN-1];
        sign_b_s = !ex_funct[0] && ex_opB[XLEN-1];
        mag_a_s  = sign_a_s ? -ex_opA : ex_opA;
        mag_b_s  = sign_b_s ? -ex_opB : ex_opB;
    end

    muldiv_datapath #(.XLEN(XLEN)) u_datapath (
        .acc_i      (acc_q),
        .opb_i      (opb_q),
        .is_div_i   (is_div_q),
        .neg_q_i    (neg_q_q),
        .neg_r_i    (neg_r_q),
        .acc_step_o (acc_step_s),
        .hi_fix_o   (hi_fix_s),
        .lo_fix_o   (lo_fix_s)
    );

    // Sequencer next state and HI/LO update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            IDLE: begin
                if (start_s && !ex_flush) begin
                    acc_d    = {{XLEN{1'b0}}, mag_a_s};
                    opb_d    = mag_b_s;
                    is_div_d = ex_funct[1];
                    neg_q_d  = sign_a_s ^ sign_b_s;
                    neg_r_d  = sign_a_s;
                    cnt_d    = CNT_W'(XLEN-1);
                    state_d  = RUN;
                end else if (mt_s && !ex_flush) begin
                    if (ex_funct == FUNCT_MTHI) begin
                        hi_d = ex_opA;
                    end else begin
                        lo_d = ex_opA;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (ex_flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_step_s;
                    if (cnt_q == '0) begin
                        state_d = FIX;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            FIX: begin
                if (ex_flush) begin
                    state_d = IDLE;
                end else begin
                    hi_d    = hi_fix_s;
                    lo_d    = lo_fix_s;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, operand and HI/LO registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            is_div_q <= is_div_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Busy/stall and the MFHI/MFLO read port
    always_comb begin
        md_busy  = (state_q != IDLE);
        md_stall = md_busy && (start_s || mf_s || mt_s) && !ex_flush;
        if ((state_q == IDLE) && mf_s) begin
            md_result = (ex_funct == FUNCT_MFHI) ? hi_q : lo_q;
        end else begin
            md_result = '0;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit with hand-computed results.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_rtype;
    logic [5:0]  ex_funct;
    logic [31:0] ex_opA, ex_opB;
    logic        ex_flush;
    logic        md_stall, md_busy;
    logic [31:0] md_result, hi, lo;

    int checks = 0;
    int failures = 0;
    int n;

    ex_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ex_rtype  (ex_rtype),
        .ex_funct  (ex_funct),
        .ex_opA    (ex_opA),
        .ex_opB    (ex_opB),
        .ex_flush  (ex_flush),
        .md_stall  (md_stall),
        .md_busy   (md_busy),
        .md_result (md_result),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rt, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        ex_rtype = rt;
        ex_funct = f;
        ex_opA   = a;
        ex_opB   = b;
    endtask

    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cnt;
        drive(1'b1, f, a, b);
        #1;
        chk({tag, "_accept_stall"}, {31'd0, md_stall}, 32'd0);
        step();
        drive(1'b0, 6'h00, 32'd0, 32'd0);
        cnt = 0;
        while (md_busy && cnt < 100) begin
            cnt++;
            step();
        end
        chk({tag, "_busy_cycles"}, cnt, 32'd33);
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        rst_n    = 1'b0;
        ex_flush = 1'b0;
        drive(1'b0, 6'h00, 32'd0, 32'd0);
        #3;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, md_busy}, 32'd0);
        chk("rst_stall", {31'd0, md_stall}, 32'd0);
        chk("rst_result", md_result, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        drive(1'b1, 6'h10, 32'd0, 32'd0);
        #1;
        chk("mfhi_reset", md_result, 32'd0);
        chk("mfhi_stall", {31'd0, md_stall}, 32'd0);
        drive(1'b1, 6'h12, 32'd0, 32'd0);
        #1;
        chk("mflo_reset", md_result, 32'd0);
        step();

        run_op("mult",   6'h18, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op("multu",  6'h19, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA);
        run_op("div",    6'h1A, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu0",  6'h1B, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF);
        run_op("divovf", 6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

        // MULT then MFLO held in EX: ADD never stalls, MFLO stalls until HI/LO are written
        drive(1'b1, 6'h18, 32'd5, 32'd6);
        step();
        drive(1'b1, 6'h20, 32'd0, 32'd0);
        #1;
        chk("add_busy_nostall", {31'd0, md_stall}, 32'd0);
        chk("add_busy", {31'd0, md_busy}, 32'd1);
        step();
        drive(1'b1, 6'h12, 32'd0, 32'd0);
        #1;
        n = 0;
        while (md_stall && n < 100) begin
            n++;
            step();
        end
        chk("mflo_stall_cycles", n, 32'd32);
        chk("mflo_new_lo", md_result, 32'd30);
        chk("mflo_idle", {31'd0, md_busy}, 32'd0);
        step();

        // MTHI/MTLO, then flush suppression in IDLE
        drive(1'b1, 6'h11, 32'h1234, 32'd0);
        #1;
        chk("mthi_stall", {31'd0, md_stall}, 32'd0);
        step();
        drive(1'b1, 6'h13, 32'h5678, 32'd0);
        step();
        chk("mthi_hi", hi, 32'h1234);
        chk("mtlo_lo", lo, 32'h5678);
        drive(1'b1, 6'h10, 32'd0, 32'd0);
        #1;
        chk("mfhi_read", md_result, 32'h1234);
        ex_flush = 1'b1;
        drive(1'b1, 6'h18, 32'd2, 32'd2);
        step();
        chk("flush_idle_nostart", {31'd0, md_busy}, 32'd0);
        drive(1'b1, 6'h11, 32'hDEAD, 32'd0);
        step();
        chk("flush_idle_nomt", hi, 32'h1234);
        ex_flush = 1'b0;

        // DIV aborted on RUN cycle 10
        drive(1'b1, 6'h1A, 32'd100, 32'd7);
        step();
        drive(1'b0, 6'h00, 32'd0, 32'd0);
        repeat (9) step();
        chk("flush_run_busy", {31'd0, md_busy}, 32'd1);
        ex_flush = 1'b1;
        drive(1'b1, 6'h1A, 32'd1, 32'd1);
        #1;
        chk("flush_forces_nostall", {31'd0, md_stall}, 32'd0);
        step();
        ex_flush = 1'b0;
        drive(1'b0, 6'h00, 32'd0, 32'd0);
        chk("flush_abort_idle", {31'd0, md_busy}, 32'd0);
        chk("flush_hi_kept", hi, 32'h1234);
        chk("flush_lo_kept", lo, 32'h5678);

        // Start presented while busy is held and accepted on the first IDLE cycle
        drive(1'b1, 6'h1B, 32'd20, 32'd3);
        step();
        drive(1'b1, 6'h19, 32'd7, 32'd9);
        #1;
        n = 0;
        while (md_stall && n < 100) begin
            n++;
            step();
        end
        chk("reaccept_stall_cycles", n, 32'd33);
        chk("divu_hi", hi, 32'd2);
        chk("divu_lo", lo, 32'd6);
        step();
        drive(1'b0, 6'h00, 32'd0, 32'd0);
        n = 0;
        while (md_busy && n < 100) begin
            n++;
            step();
        end
        chk("reaccept_busy_cycles", n, 32'd33);
        chk("reaccept_hi", hi, 32'd0);
        chk("reaccept_lo", lo, 32'd63);

        // Asynchronous reset in the middle of RUN
        drive(1'b1, 6'h18, 32'd3, 32'd3);
        step();
        drive(1'b1, 6'h12, 32'd0, 32'd0);
        repeat (4) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, md_busy}, 32'd0);
        chk("arst_stall", {31'd0, md_stall}, 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        chk("arst_result", md_result, 32'd0);
        drive(1'b0, 6'h00, 32'd0, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        run_op("multu_post_rst", 6'h19, 32'h00010000, 32'h00010000, 32'd1, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
